// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared transmitter sending address/command frames and repeat codes on a 38 kHz carrier
module nec_ir_tx #(
    parameter int LEAD_MARK    = 450000,
    parameter int LEAD_SPACE   = 225000,
    parameter int REP_SPACE    = 112500,
    parameter int T_UNIT       = 28000,
    parameter int ONE_SPACE    = 84500,
    parameter int FRAME_PERIOD = 5400000,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       repeat_req,
    output logic       busy,
    output logic       done,
    output logic       inf_env,
    output logic       inf_out
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE,
        S_STOP_MARK, S_GAP, S_REP_MARK, S_REP_SPACE, S_REP_STOP
    } state_t;
    localparam int CW = $clog2(CARRIER_DIV);
    localparam logic [22:0] D_LM  = 23'(LEAD_MARK - 1);
    localparam logic [22:0] D_LS  = 23'(LEAD_SPACE - 1);
    localparam logic [22:0] D_RS  = 23'(REP_SPACE - 1);
    localparam logic [22:0] D_T   = 23'(T_UNIT - 1);
    localparam logic [22:0] D_ONE = 23'(ONE_SPACE - 1);
    localparam logic [22:0] D_FP  = 23'(FRAME_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] C_HIGH = CW'(CARRIER_HIGH);
    state_t        st, st_n;
    logic [22:0]   cnt, fcnt, dur;
    logic [CW-1:0] ccnt, ccnt_n;
    logic [31:0]   sh;
    logic [4:0]    bit_cnt;
    logic          last, mark_n, enter_mark;
    always_comb begin
        dur = (st == S_LEAD_MARK || st == S_REP_MARK) ? D_LM :
              (st == S_LEAD_SPACE) ? D_LS :
              (st == S_REP_SPACE) ? D_RS :
              (st == S_BIT_SPACE && sh[0]) ? D_ONE : D_T;
        last = (st == S_GAP) ? (fcnt == D_FP) : (cnt == dur);
        st_n = st;
        case (st)
            S_IDLE:       st_n = start ? S_LEAD_MARK : S_IDLE;
            S_LEAD_MARK:  if (last) st_n = S_LEAD_SPACE;
            S_LEAD_SPACE: if (last) st_n = S_BIT_MARK;
            S_BIT_MARK:   if (last) st_n = S_BIT_SPACE;
            S_BIT_SPACE:  if (last) st_n = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  if (last) st_n = S_GAP;
            S_GAP:        if (last) st_n = repeat_req ? S_REP_MARK : S_IDLE;
            S_REP_MARK:   if (last) st_n = S_REP_SPACE;
            S_REP_SPACE:  if (last) st_n = S_REP_STOP;
            S_REP_STOP:   if (last) st_n = S_GAP;
            default:      st_n = S_IDLE;
        endcase
        mark_n = st_n inside {S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK, S_REP_MARK, S_REP_STOP};
        // every mark restarts the carrier so it opens on a high phase
        enter_mark = mark_n && (st_n != st);
        ccnt_n = (enter_mark || ccnt == C_LAST) ? '0 : ccnt + 1'b1;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st      <= S_IDLE;
            cnt     <= '0;
            fcnt    <= '0;
            ccnt    <= '0;
            sh      <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            inf_env <= 1'b0;
            inf_out <= 1'b0;
        end else begin
            st   <= st_n;
            cnt  <= (st_n != st) ? '0 : cnt + 1'b1;
            fcnt <= ((st_n == S_LEAD_MARK || st_n == S_REP_MARK) && st_n != st) ? '0 : fcnt + 1'b1;
            ccnt <= ccnt_n;
            if (st == S_IDLE && start) begin
                sh      <= {~data, data, ~addr, addr};
                bit_cnt <= '0;
            end else if (st == S_BIT_SPACE && last) begin
                sh      <= sh >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            busy    <= st_n != S_IDLE;
            done    <= st == S_GAP && st_n == S_IDLE;
            inf_env <= mark_n;
            inf_out <= mark_n && ccnt_n < C_HIGH;
        end
    end
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: randomized bench for nec_ir_tx against a segment-list model of the NEC waveform
module tb_nec_ir_tx;
    localparam int LM = 40, LS = 20, RS = 10, TU = 3, ONE = 7, FP = 400, CD = 7, CH = 3;
    localparam int HSZ = 32768;
    logic       sys_clk = 0, sys_rst = 1, start = 0, repeat_req = 0;
    logic [7:0] addr = 0, data = 0;
    logic       busy, done, inf_env, inf_out;
    int n_chk = 0, n_fail = 0, cyc = 0, e0 = 0, ph = 0;
    bit en = 0;
    bit env_h[HSZ], out_h[HSZ];
    logic        m_busy = 0, m_done = 0, m_rep = 0;
    logic [31:0] m_word = 0;
    int          m_k = 0;

    nec_ir_tx #(
        .LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS), .T_UNIT(TU), .ONE_SPACE(ONE),
        .FRAME_PERIOD(FP), .CARRIER_DIV(CD), .CARRIER_HIGH(CH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .addr(addr), .data(data),
        .repeat_req(repeat_req), .busy(busy), .done(done), .inf_env(inf_env), .inf_out(inf_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Position within a frame as a list of mark/space segments; returns carrier phase in a mark, -1 in a space.
    function automatic int phase_at(input logic rep, input logic [31:0] w, input int k);
        int  d[$];
        bit  mk[$];
        int  t;
        t = k;
        d.push_back(LM); mk.push_back(1);
        if (rep) begin
            d.push_back(RS); mk.push_back(0);
        end else begin
            d.push_back(LS); mk.push_back(0);
            for (int i = 0; i < 32; i++) begin
                d.push_back(TU); mk.push_back(1);
                d.push_back(w[i] ? ONE : TU); mk.push_back(0);
            end
        end
        d.push_back(TU); mk.push_back(1);
        foreach (d[i]) begin
            if (t < d[i]) return mk[i] ? t : -1;
            t -= d[i];
        end
        return -1;
    endfunction

    always @(posedge sys_clk) begin
        cyc    <= cyc + 1;
        m_done <= 0;
        if (sys_rst) begin
            m_busy <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1;
                m_rep  <= 0;
                m_k    <= 0;
                m_word <= {~data, data, ~addr, addr};
            end
        end else if (m_k == FP - 1) begin
            if (repeat_req) begin
                m_rep <= 1;
                m_k   <= 0;
            end else begin
                m_busy <= 0;
                m_done <= 1;
            end
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge sys_clk) begin
        if (cyc < HSZ) begin
            env_h[cyc] = inf_env;
            out_h[cyc] = inf_out;
        end
        if (en) begin
            ph = m_busy ? phase_at(m_rep, m_word, m_k) : -1;
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("inf_env", int'(inf_env), int'(ph >= 0));
            chk("inf_out", int'(inf_out), int'(ph >= 0 && (ph % CD) < CH));
        end
    end

    function automatic bit envr(input int r);
        return env_h[e0 + r - 1];
    endfunction

    function automatic int count_hi(input int a, input int b);
        int n = 0;
        for (int r = a; r <= b; r++) n += int'(envr(r));
        return n;
    endfunction

    task automatic do_start(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        data  = d;
        start = 1;
        @(negedge sys_clk);
        start = 0;
        e0    = cyc;
        addr  = 8'($urandom);
        data  = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    initial begin
        int runs_one, runs_t, run, last_hi, lead_out, drop, k;
        @(negedge sys_clk);
        en = 1;
        @(negedge sys_clk);
        sys_rst = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_env", int'(inf_env), 0);
        chk("rst_out", int'(inf_out), 0);
        chk("rst_done", int'(done), 0);

        // Fixed frame addr=0x00 data=0x16 with an ignored start while busy
        do_start(8'h00, 8'h16);
        repeat (100) @(negedge sys_clk);
        addr = 8'h55; start = 1;
        @(negedge sys_clk);
        start = 0;
        wait_done(FP + 50);
        chk("f1_done_rel", cyc - e0 + 1, FP + 1);
        chk("f1_busy_in_done", int'(busy), 0);
        runs_one = 0; runs_t = 0; run = 0; last_hi = 0; lead_out = 0;
        for (int r = 1; r <= FP; r++) begin
            if (envr(r)) begin
                if (run == ONE) runs_one++;
                else if (run == TU) runs_t++;
                run = 0;
                last_hi = r;
            end else run++;
        end
        for (int r = 1; r <= LM; r++) lead_out += int'(out_h[e0 + r - 1]);
        chk("f1_first_env", int'(envr(1)), 1);
        chk("f1_first_out", int'(out_h[e0]), 1);
        chk("f1_hi_count", count_hi(1, FP), LM + 33 * TU);
        chk("f1_last_hi", last_hi, 319);
        chk("f1_one_spaces", runs_one, 16);
        chk("f1_zero_spaces", runs_t, 16);
        chk("f1_lead_out_hi", lead_out, 18);
        chk("f1_bit0_space", int'(envr(66)), 0);
        chk("f1_bit1_mark", int'(envr(67)), 1);
        chk("f1_bit8_space", int'(envr(118)), 0);
        chk("f1_bit9_mark", int'(envr(119)), 1);
        repeat (50) @(negedge sys_clk);
        chk("f1_no_second", int'(busy), 0);

        // Reset mid-frame, then a fresh frame
        do_start(8'($urandom), 8'($urandom));
        repeat (150) @(negedge sys_clk);
        sys_rst = 1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_env", int'(inf_env), 0);
        chk("mid_rst_out", int'(inf_out), 0);
        chk("mid_rst_done", int'(done), 0);
        do_start(8'hA5, 8'h3C);
        chk("post_rst_busy", int'(busy), 1);
        chk("post_rst_env", int'(inf_env), 1);
        wait_done(FP + 50);

        // Two repeat codes, then release
        repeat (3) @(negedge sys_clk);
        repeat_req = 1;
        do_start(8'($urandom), 8'($urandom));
        repeat (2 * FP + 100) @(negedge sys_clk);
        repeat_req = 0;
        wait_done(FP + 50);
        chk("rep_done_rel", cyc - e0 + 1, 3 * FP + 1);
        chk("rep1_before", int'(envr(FP)), 0);
        chk("rep1_mark", int'(envr(FP + 1)), 1);
        chk("rep1_mark_end", int'(envr(FP + LM)), 1);
        chk("rep1_space", int'(envr(FP + LM + 1)), 0);
        chk("rep1_space_end", int'(envr(FP + LM + RS)), 0);
        chk("rep1_stop", int'(envr(FP + LM + RS + 1)), 1);
        chk("rep1_after", int'(envr(FP + LM + RS + TU + 1)), 0);
        chk("rep1_hi_count", count_hi(FP + 1, 2 * FP), LM + TU);
        chk("rep2_mark", int'(envr(2 * FP + 1)), 1);

        // Back-to-back start in the done cycle
        chk("b2b_busy_drop", int'(busy), 0);
        do_start(8'($urandom), 8'($urandom));
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_env", int'(inf_env), 1);
        wait_done(FP + 50);

        for (int it = 0; it < 6; it++) begin
            repeat_req = ($urandom_range(0, 2) == 0);
            drop = $urandom_range(0, 2 * FP);
            do_start(8'($urandom), 8'($urandom));
            k = 0;
            while (k < 4 * FP) begin
                start = 0;
                if (k == drop) repeat_req = 0;
                if ($urandom_range(0, 31) == 0) begin
                    start = 1;
                    addr = 8'($urandom);
                end
                @(negedge sys_clk);
                k++;
                if (done) break;
            end
            start = 0;
            repeat_req = 0;
            chk("rnd_done_reached", int'(done), 1);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 5)) @(negedge sys_clk);
        end
        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
